// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues one-cycle-latency IMEM reads and
// buffers {PC, PC+1, instr} entries for decode. Optional IFQ_BYPASS_EN presents a response directly when empty.
module instr_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     PCSrcE,
  input  logic [XLEN-1:0]          PCTargetE,
  input  logic                     StallD,
  output logic                     ImemReq,
  output logic [XLEN-1:0]          ImemAddr,
  input  logic [XLEN-1:0]          ImemRData,
  output logic                     ValidF,
  output logic [XLEN-1:0]          PCF,
  output logic [XLEN-1:0]          PCPlus4F,
  output logic [XLEN-1:0]          InstrF,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus1;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_addr_q, inflight_addr_d;
  logic            inflight_q, inflight_d;

  entry_t          resp, head_entry;
  logic            bypass_hit, deq, fifo_pop, fifo_push, req;
  logic [CW:0]     occupied, capacity;

  assign resp       = '{pc: inflight_addr_q, pc_plus1: inflight_addr_q + XLEN'(1), instr: ImemRData};
  assign head_entry = fifo_q[head_q];

`ifdef IFQ_BYPASS_EN
  // A discarded (redirect/reset) response must never be shown to decode.
  assign bypass_hit = inflight_q && (count_q == '0) && !PCSrcE && !reset;
`else
  assign bypass_hit = 1'b0;
`endif

  assign ValidF   = bypass_hit || (count_q != '0);
  assign PCF      = bypass_hit ? resp.pc       : head_entry.pc;
  assign PCPlus4F = bypass_hit ? resp.pc_plus1 : head_entry.pc_plus1;
  assign InstrF   = bypass_hit ? resp.instr    : head_entry.instr;
  assign Count    = count_q;

  assign deq       = ValidF && !StallD;
  assign fifo_pop  = deq && !bypass_hit;
  assign fifo_push = inflight_q && !(bypass_hit && deq);

  // Credit rule: slots left after the in-flight response lands, plus one if a slot frees this cycle.
  assign occupied = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign capacity = (CW+1)'(DEPTH) + {{CW{1'b0}}, deq};
  assign req      = (occupied < capacity) && !reset && !PCSrcE;

  assign ImemReq  = req;
  assign ImemAddr = fetch_pc_q;

  // NOTE: every next-state signal gets a default before any branch so no latch is inferred.
  always_comb begin
    fetch_pc_d      = fetch_pc_q;
    inflight_d      = req;
    inflight_addr_d = req ? fetch_pc_q : inflight_addr_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    if (PCSrcE) begin
      fetch_pc_d = PCTargetE;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (req)       fetch_pc_d = fetch_pc_q + XLEN'(1);
      if (fifo_push) tail_d     = tail_q + PW'(1);
      if (fifo_pop)  head_d     = head_q + PW'(1);
      count_d = count_q + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q      <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
    end
  end

  // NOTE: the storage is reset (it is only a few entries) so the head outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (fifo_push && !PCSrcE) begin
      fifo_q[tail_q] <= resp;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: stimulus pushes expected fetch entries, a negedge
// monitor compares every accepted head entry; directed checks cover reset, stall, redirect, wrap.
module tb_instr_fetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, PCSrcE, StallD;
  logic [31:0] PCTargetE;
  logic        ImemReq, ValidF;
  logic [31:0] ImemAddr, PCF, PCPlus4F, InstrF;
  logic [31:0] ImemRData = '0;
  logic [2:0]  Count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc1;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  instr_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'd0)) dut (
    .clk       (clk),
    .reset     (reset),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .StallD    (StallD),
    .ImemReq   (ImemReq),
    .ImemAddr  (ImemAddr),
    .ImemRData (ImemRData),
    .ValidF    (ValidF),
    .PCF       (PCF),
    .PCPlus4F  (PCPlus4F),
    .InstrF    (InstrF),
    .Count     (Count)
  );

  // Synchronous instruction memory: IMEM[a] = 0x1000 + a.
  always @(posedge clk) begin
    if (ImemReq) ImemRData <= 32'h1000 + ImemAddr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.pc1   = pc + 32'd1;
    e.instr = 32'h1000 + pc;
    return e;
  endfunction

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(start + 32'(i)));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every entry decode accepts must be the next expected one.
  always @(negedge clk) begin
    if (reset === 1'b0 && PCSrcE === 1'b0 && ValidF === 1'b1 && StallD === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got PCF %0h expected no entry at %0t", PCF, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pc", PCF, mon_e.pc);
        check("sb_pc1", PCPlus4F, mon_e.pc1);
        check("sb_instr", InstrF, mon_e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit drained;
    reset     = 1'b1;
    PCSrcE    = 1'b0;
    StallD    = 1'b0;
    PCTargetE = '0;
    drained   = 1'b0;

    // Reset state.
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_valid", 32'(ValidF), 32'd0);
    check("rst_req", 32'(ImemReq), 32'd0);
    check("rst_count", 32'(Count), 32'd0);
    check("rst_pcf", PCF, 32'd0);
    check("rst_pc1", PCPlus4F, 32'd0);
    check("rst_instr", InstrF, 32'd0);
    check("rst_addr", ImemAddr, 32'd0);

    // Streaming from reset release: first request in the first cycle.
    next_cycle();
    reset = 1'b0;
    push_seq(32'd0, 64);
    @(negedge clk);
    check("c0_req", 32'(ImemReq), 32'd1);
    check("c0_addr", ImemAddr, 32'd0);
    check("c0_valid", 32'(ValidF), 32'd0);
    next_cycle();
    @(negedge clk);
    check("c1_addr", ImemAddr, 32'd1);
    check("c1_valid", 32'(ValidF), BYP ? 32'd1 : 32'd0);
    next_cycle();
    @(negedge clk);
    check("c2_addr", ImemAddr, 32'd2);
    check("c2_valid", 32'(ValidF), 32'd1);
    repeat (3) next_cycle();

    // Ten-cycle stall: queue fills, requests stop, fetch PC holds.
    next_cycle();
    StallD = 1'b1;
    repeat (9) next_cycle();
    @(negedge clk);
    check("full_count", 32'(Count), 32'd4);
    check("full_req", 32'(ImemReq), 32'd0);
    check("full_addr", ImemAddr, BYP ? 32'd9 : 32'd8);
    check("full_head", PCF, BYP ? 32'd5 : 32'd4);

    // Release: drains in order while refilling; Count settles at 3 with one in flight.
    next_cycle();
    StallD = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("steady_count", 32'(Count), 32'd3);

    // Redirect with Count=3, a response in flight and a dequeue in the same cycle.
    next_cycle();
    PCSrcE    = 1'b1;
    PCTargetE = 32'h40;
    exp_q.delete();
    push_seq(32'h40, 64);
    @(negedge clk);
    check("redir_count", 32'(Count), 32'd3);
    check("redir_valid", 32'(ValidF), 32'd1);
    check("redir_req", 32'(ImemReq), 32'd0);
    next_cycle();
    PCSrcE = 1'b0;
    @(negedge clk);
    check("redir1_count", 32'(Count), 32'd0);
    check("redir1_valid", 32'(ValidF), 32'd0);
    check("redir1_req", 32'(ImemReq), 32'd1);
    check("redir1_addr", ImemAddr, 32'h40);
    next_cycle();
    @(negedge clk);
    check("redir2_valid", 32'(ValidF), BYP ? 32'd1 : 32'd0);
    check("redir2_addr", ImemAddr, 32'h41);
    next_cycle();
    @(negedge clk);
    check("redir3_valid", 32'(ValidF), 32'd1);

    // Build Count=2 with a response in flight, then reset mid-operation.
    next_cycle();
    StallD = 1'b1;
    next_cycle();
    @(negedge clk);
    check("pre_rst_count", 32'(Count), BYP ? 32'd1 : 32'd2);
    next_cycle();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_gate_req", 32'(ImemReq), 32'd0);
    next_cycle();
    @(negedge clk);
    check("mrst_count", 32'(Count), 32'd0);
    check("mrst_valid", 32'(ValidF), 32'd0);
    check("mrst_pcf", PCF, 32'd0);
    check("mrst_pc1", PCPlus4F, 32'd0);
    check("mrst_instr", InstrF, 32'd0);
    check("mrst_addr", ImemAddr, 32'd0);
    next_cycle();
    reset  = 1'b0;
    StallD = 1'b0;
    push_seq(32'd0, 64);
    @(negedge clk);
    check("restart_req", 32'(ImemReq), 32'd1);
    check("restart_addr", ImemAddr, 32'd0);
    repeat (4) next_cycle();

    // PC wrap: redirect to the top of the address space while decode is stalled.
    next_cycle();
    PCSrcE    = 1'b1;
    PCTargetE = 32'hFFFF_FFFF;
    StallD    = 1'b1;
    exp_q.delete();
    next_cycle();
    PCSrcE = 1'b0;
    @(negedge clk);
    check("wrap_addr0", ImemAddr, 32'hFFFF_FFFF);
    check("wrap_req", 32'(ImemReq), 32'd1);
    next_cycle();
    @(negedge clk);
    check("wrap_addr1", ImemAddr, 32'd0);
    next_cycle();
    @(negedge clk);
    check("wrap_valid", 32'(ValidF), 32'd1);
    check("wrap_pcf", PCF, 32'hFFFF_FFFF);
    check("wrap_pc1", PCPlus4F, 32'd0);
    check("wrap_instr", InstrF, 32'h0000_0FFF);

    // Drain an exact window across the wrap, then stall again.
    push_seq(32'hFFFF_FFFF, 6);
    next_cycle();
    StallD = 1'b0;
    for (int i = 0; i < 30; i++) begin
      next_cycle();
      if (exp_q.size() == 0) begin
        StallD  = 1'b1;
        drained = 1'b1;
        break;
      end
    end
    repeat (3) next_cycle();
    check("drain_done", 32'(drained), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
